// File: rtl/cic_comp_pkg.sv
// rtl/cic_comp_pkg.sv - shared constants, coefficients and FSM state type for the CIC compensation FIR
package cic_comp_pkg;

    localparam int NUM_TAPS   = 11;
    localparam int COEFF_FRAC = 15;
    localparam int TAP_IDX_W  = 4;

    localparam logic [TAP_IDX_W-1:0] LAST_TAP = TAP_IDX_W'(NUM_TAPS - 1);

    // Symmetric Q1.15 taps: plain sum 32768 (unity DC gain),
    // alternating-sign sum 40960 (Nyquist gain 1.25) to lift the CIC droop.
    localparam logic signed [15:0] COEFFS [NUM_TAPS] = '{
        16'sd256,  16'sd512,  16'sd1792, -16'sd1536, 16'sd16384, -16'sd2048,
        16'sd16384, -16'sd1536, 16'sd1792, 16'sd512, 16'sd256
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2
    } state_t;

    // Circular-buffer pointer step forward with wrap at NUM_TAPS.
    function automatic logic [TAP_IDX_W-1:0] ptr_inc(input logic [TAP_IDX_W-1:0] p);
        return (p == LAST_TAP) ? '0 : p + 1'b1;
    endfunction

    // Circular-buffer pointer step backward with wrap at NUM_TAPS.
    function automatic logic [TAP_IDX_W-1:0] ptr_dec(input logic [TAP_IDX_W-1:0] p);
        return (p == '0) ? LAST_TAP : p - 1'b1;
    endfunction

endpackage

// File: rtl/cic_comp_mac.sv
// rtl/cic_comp_mac.sv - signed multiply-accumulate with synchronous clear and enable
module cic_comp_mac #(
    parameter int A_WIDTH   = 12,
    parameter int B_WIDTH   = 16,
    parameter int ACC_WIDTH = 36
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clear,
    input  logic                        i_en,
    input  logic signed [A_WIDTH-1:0]   i_a,
    input  logic signed [B_WIDTH-1:0]   i_b,
    output logic signed [ACC_WIDTH-1:0] o_acc
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    logic signed [P_WIDTH-1:0]   w_prod;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] r_acc;

    assign w_prod     = i_a * i_b;
    assign w_prod_ext = {{(ACC_WIDTH-P_WIDTH){w_prod[P_WIDTH-1]}}, w_prod};
    assign o_acc      = r_acc;

    // Accumulate one full-width product per enabled cycle; clear wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

endmodule

// File: rtl/cic_comp_fir.sv
// rtl/cic_comp_fir.sv - 11-tap CIC droop compensation FIR, narrowing selected by CIC_COMP_SATURATE_EN
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int INPUT_WIDTH = 12,
    parameter int COEFF_WIDTH = 16,
    parameter int ACC_WIDTH   = 36
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [INPUT_WIDTH-1:0] data_in,
    input  logic                          data_clk_in,
    output logic signed [INPUT_WIDTH-1:0] data_out,
    output logic                          data_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS =
        {{(ACC_WIDTH-COEFF_FRAC){1'b0}}, 1'b1, {(COEFF_FRAC-1){1'b0}}};

    state_t                        r_state;
    logic                          r_clk_prev;
    logic signed [INPUT_WIDTH-1:0] r_buf [NUM_TAPS];
    logic [TAP_IDX_W-1:0]          r_wr_ptr;
    logic [TAP_IDX_W-1:0]          r_rd_ptr;
    logic [TAP_IDX_W-1:0]          r_tap;
    logic signed [INPUT_WIDTH-1:0] r_data_out;
    logic                          r_data_valid;
    logic                          r_busy;
    logic                          r_overrun;

    logic                          w_edge;
    logic                          w_mac_clr;
    logic                          w_mac_en;
    logic signed [INPUT_WIDTH-1:0] w_sample;
    logic signed [COEFF_WIDTH-1:0] w_coeff;
    logic signed [ACC_WIDTH-1:0]   w_acc;
    logic signed [ACC_WIDTH-1:0]   w_biased;
    logic signed [ACC_WIDTH-1:0]   w_shifted;
    logic signed [INPUT_WIDTH-1:0] w_result;

    assign w_edge    = data_clk_in & ~r_clk_prev;
    assign w_mac_clr = (r_state == IDLE) && w_edge;
    assign w_mac_en  = (r_state == MAC);
    assign w_sample  = r_buf[r_rd_ptr];
    assign w_coeff   = COEFF_WIDTH'(COEFFS[r_tap]);

    cic_comp_mac #(
        .A_WIDTH   (INPUT_WIDTH),
        .B_WIDTH   (COEFF_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_mac_clr),
        .i_en    (w_mac_en),
        .i_a     (w_sample),
        .i_b     (w_coeff),
        .o_acc   (w_acc)
    );

    assign w_biased  = w_acc + ROUND_BIAS;
    assign w_shifted = w_biased >>> COEFF_FRAC;

`ifdef CIC_COMP_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-INPUT_WIDTH+1){1'b0}}, {(INPUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-INPUT_WIDTH+1){1'b1}}, {(INPUT_WIDTH-1){1'b0}}};

    // Clamp the rounded result into the output sample range.
    always_comb begin
        w_result = INPUT_WIDTH'(w_shifted);
        if (w_shifted > SAT_MAX) begin
            w_result = INPUT_WIDTH'(SAT_MAX);
        end else if (w_shifted < SAT_MIN) begin
            w_result = INPUT_WIDTH'(SAT_MIN);
        end
    end
`else
    // Keep only the low bits of the rounded result (two's-complement wrap).
    always_comb begin
        w_result = INPUT_WIDTH'(w_shifted);
    end
`endif

    // Sequencer: capture sample on edge, walk taps newest-to-oldest, round, publish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_clk_prev   <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_tap        <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_clk_prev   <= data_clk_in;
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_edge) begin
                        r_buf[r_wr_ptr] <= data_in;
                        r_rd_ptr        <= r_wr_ptr;
                        r_wr_ptr        <= ptr_inc(r_wr_ptr);
                        r_tap           <= '0;
                        r_busy          <= 1'b1;
                        r_state         <= MAC;
                    end
                end
                MAC: begin
                    r_overrun <= w_edge;
                    r_rd_ptr  <= ptr_dec(r_rd_ptr);
                    if (r_tap == LAST_TAP) begin
                        r_state <= ROUND;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                ROUND: begin
                    r_overrun    <= w_edge;
                    r_data_out   <= w_result;
                    r_data_valid <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

endmodule
